ann_argmax: RTL and testbench
=============================

Name: ann_argmax

Overview:
- Downstream stage of the fully-connected classifier: takes the NUM_CLASSES IEEE-754 single-precision output scores and returns the index and value of the largest score.
- Scans one element per cycle after a start strobe, so a single float comparator serves any class count.
- Snapshots its input on start, so the upstream network may begin its next frame immediately.

Parameters:
- DATA_WIDTH, 32, score width; IEEE-754 binary32, fixed at 32.
- NUM_CLASSES, 4, number of scores; must be ≥ 2.
- IDX_WIDTH, 2, class index width; equals clog2(NUM_CLASSES), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle strobe; scores are valid in the same cycle.
- scores  in  DATA_WIDTH*NUM_CLASSES  packed scores; element i occupies bits [32*i+31:32*i].
- busy  out  1  high while a scan is in progress (SCAN state).
- valid_out  out  1  one-cycle pulse when class_idx and max_score are updated.
- class_idx  out  IDX_WIDTH  index of the winning score.
- max_score  out  DATA_WIDTH  raw bits of the winning score.

Behaviour:
- Reset (async): state=IDLE, busy=0, valid_out=0, class_idx=0, max_score=0, snapshot=0, counter=0.
- States: IDLE, SCAN, DONE.
- IDLE + start:
  - latch scores into the snapshot register;
  - best_val=element0, best_idx=0, cnt=1;
  - go to SCAN.
- IDLE without start: stay in IDLE.
- SCAN, every cycle:
  - compare element[cnt] against best_val;
  - if the candidate wins, best_val=element[cnt] and best_idx=cnt;
  - if cnt==NUM_CLASSES-1, go to DONE; otherwise cnt+1.
- DONE, one cycle:
  - valid_out=1; class_idx=best_idx and max_score=best_val are registered;
  - go to IDLE, or start a new scan directly if start is high this cycle (back-to-back).
- Latency:
  - start sampled at edge T;
  - SCAN occupies edges T+1 .. T+NUM_CLASSES-1;
  - valid_out is high for exactly one cycle following edge T+NUM_CLASSES (4 cycles with the default).
- Throughput: one result per NUM_CLASSES cycles with back-to-back starts.
- class_idx and max_score hold their value between valid_out pulses and change only in DONE.
- start while in SCAN is ignored; no queueing, no error flag.
- Compare rule ("candidate wins"):
  - a NaN candidate (exp=0xFF, mant≠0) never wins;
  - a non-NaN candidate always beats a NaN best;
  - otherwise wins only if strictly greater by IEEE ordering.
- Float ordering:
  - map x to a 32-bit unsigned key: if sign=0, key = x | 0x80000000; if sign=1, key = ~x;
  - compare keys;
  - +0 and −0 are treated as equal (both keys are normalised to 0x80000000 first);
  - ±Inf are ordered naturally.
- Ties: the lowest index wins, because replacement requires strictly greater.
- All-NaN input: class_idx=0 and max_score=element0 bits.
- Reset asserted mid-scan: immediate return to reset values; no valid_out is produced for the aborted scan.
- valid_out and busy are never high in the same cycle.

Decomposition:
- Shared package:
  - FP32_NAN_EXP = 8'hFF;
  - FP32_SIGN_BIT = 31;
  - state encoding constants S_IDLE, S_SCAN, S_DONE;
  - function fp32_key(x) returning the ordering key.
- Sub-module fp32_gt (combinational): inputs a, b; outputs a_gt_b and a_is_nan. It is reused by any later max-pool stage.

Test Plan:
- Scores {e0=3F000000 (0.5), e1=40000000 (2.0), e2=3F800000 (1.0), e3=BF800000 (−1.0)}, start at T → valid_out pulse at T+4, class_idx=1, max_score=40000000; busy high for cycles T+1..T+3.
- Ties {3F800000, 3F800000, 3F800000, 3F800000} → class_idx=0; {80000000 (−0), 00000000, 00000000, 00000000} → class_idx=0 (signed zeros equal).
- NaN handling:
  - {7FC00000 (NaN), BF800000, C0000000, 7FC00000} → class_idx=1, max_score=BF800000;
  - all 7FC00000 → class_idx=0, max_score=7FC00000.
- Snapshot and back-to-back:
  - change scores to {0, 0, 0, 40400000} the cycle after start → result still from the latched frame;
  - start again in the DONE cycle → second valid_out exactly 4 cycles after the first.
- Ignored start: assert start during SCAN → ignored, exactly one valid_out per accepted start.
- Reset mid-scan: reset asserted at T+2 → outputs zero immediately, no valid_out; a new start after release yields a correct result.

Source files
------------

// File: rtl/ann_argmax_pkg.sv
// rtl/ann_argmax_pkg.sv - shared constants, state encoding and fp32 ordering key
package ann_argmax_pkg;

  localparam logic [7:0] FP32_NAN_EXP  = 8'hFF;
  localparam int         FP32_SIGN_BIT = 31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Monotonic unsigned key; both signed zeros collapse onto the +0 key.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    if (x[30:0] == 31'd0)
      return 32'h8000_0000;
    else if (x[FP32_SIGN_BIT])
      return ~x;
    else
      return x | 32'h8000_0000;
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// rtl/fp32_gt.sv - combinational binary32 "a wins over b" comparator with NaN rules
module fp32_gt
  import ann_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b,
  output logic        a_is_nan
);

  logic b_is_nan;

  assign a_is_nan = (a[30:23] == FP32_NAN_EXP) && (a[22:0] != 23'd0);
  assign b_is_nan = (b[30:23] == FP32_NAN_EXP) && (b[22:0] != 23'd0);

  // A NaN never wins; any real value displaces a NaN incumbent.
  assign a_gt_b = !a_is_nan && (b_is_nan || (fp32_key(a) > fp32_key(b)));

endmodule

// File: rtl/ann_argmax.sv
// rtl/ann_argmax.sv - sequential argmax over NUM_CLASSES binary32 scores, one compare per cycle
module ann_argmax
  import ann_argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] scores,
  output logic                              busy,
  output logic                              valid_out,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             max_score
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                          state;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] snapshot;
  logic [DATA_WIDTH-1:0]           best_val;
  logic [DATA_WIDTH-1:0]           cand;
  logic [IDX_WIDTH-1:0]            best_idx;
  logic [IDX_WIDTH-1:0]            cnt;
  logic                            cand_gt;
  logic                            cand_nan;
  logic                            wins;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt == IDX_WIDTH'(i))
        cand = snapshot[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  fp32_gt u_gt (
    .a        (cand),
    .b        (best_val),
    .a_gt_b   (cand_gt),
    .a_is_nan (cand_nan)
  );

  assign wins = cand_gt && !cand_nan;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
      snapshot  <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      cnt       <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            snapshot <= scores;
            best_val <= scores[DATA_WIDTH-1:0];
            best_idx <= '0;
            cnt      <= IDX_WIDTH'(1);
            busy     <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (wins) begin
            best_val <= cand;
            best_idx <= cnt;
          end
          if (cnt == LAST_IDX) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            busy <= 1'b1;
            cnt  <= cnt + IDX_WIDTH'(1);
          end
        end
        S_DONE: begin
          valid_out <= 1'b1;
          class_idx <= best_idx;
          max_score <= best_val;
          if (start) begin
            // Back-to-back: busy stays low while the previous result is shown,
            // so busy and valid_out never overlap; it rises on the next scan edge.
            snapshot <= scores;
            best_val <= scores[DATA_WIDTH-1:0];
            best_idx <= '0;
            cnt      <= IDX_WIDTH'(1);
            busy     <= 1'b0;
            state    <= S_SCAN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_argmax.sv
// tb/tb_ann_argmax.sv - directed table-driven bench for ann_argmax
module tb_ann_argmax;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] scores;
  logic         busy;
  logic         valid_out;
  logic [1:0]   class_idx;
  logic [31:0]  max_score;

  int errors = 0;
  int checks = 0;

  ann_argmax #(.DATA_WIDTH(32), .NUM_CLASSES(4), .IDX_WIDTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .scores    (scores),
    .busy      (busy),
    .valid_out (valid_out),
    .class_idx (class_idx),
    .max_score (max_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] s;
    logic [1:0]   idx;
    logic [31:0]  val;
  } vec_t;

  // Elements packed {e3, e2, e1, e0}.
  localparam logic [127:0] V_MIXED = {32'hBF800000, 32'h3F800000, 32'h40000000, 32'h3F000000};
  localparam logic [127:0] V_TIE   = {4{32'h3F800000}};
  localparam logic [127:0] V_INF   = {32'h7F7FFFFF, 32'h7F800000, 32'hC0000000, 32'hFF800000};
  localparam logic [127:0] V_NAN   = {32'h7FC00000, 32'hC0000000, 32'hBF800000, 32'h7FC00000};
  localparam logic [127:0] V_LATE  = {32'h40400000, 32'h00000000, 32'h00000000, 32'h00000000};

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string nm, input logic [127:0] s, input logic [1:0] ei,
                         input logic [31:0] ev);
    int  n;
    bit  got;
    @(negedge clk);
    scores = s;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    scores = V_LATE;
    chk({nm, "_busy0"}, {31'd0, busy}, 32'd1);
    n   = 0;
    got = 0;
    while (!got && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_out) got = 1;
      else if (n < 3) chk({nm, "_busy_scan"}, {31'd0, busy}, 32'd1);
      else if (n == 3) chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
    end
    chk({nm, "_latency"}, n, 32'd4);
    chk({nm, "_busy_at_valid"}, {31'd0, busy}, 32'd0);
    chk({nm, "_idx"}, {30'd0, class_idx}, {30'd0, ei});
    chk({nm, "_val"}, max_score, ev);
    @(posedge clk);
    #1;
    chk({nm, "_pulse_width"}, {31'd0, valid_out}, 32'd0);
    chk({nm, "_idx_hold"}, {30'd0, class_idx}, {30'd0, ei});
  endtask

  initial begin
    int n;
    int pulses;
    int first_k;

    vecs[0] = '{"mixed",   V_MIXED, 2'd1, 32'h40000000};
    vecs[1] = '{"tie",     V_TIE,   2'd0, 32'h3F800000};
    vecs[2] = '{"negzero", {32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000}, 2'd0, 32'h80000000};
    vecs[3] = '{"poszero", {32'hBF800000, 32'hBF800000, 32'h80000000, 32'h00000000}, 2'd0, 32'h00000000};
    vecs[4] = '{"nan",     V_NAN,   2'd1, 32'hBF800000};
    vecs[5] = '{"allnan",  {4{32'h7FC00000}}, 2'd0, 32'h7FC00000};
    vecs[6] = '{"inf",     V_INF,   2'd2, 32'h7F800000};
    vecs[7] = '{"last",    V_LATE,  2'd3, 32'h40400000};

    reset  = 1'b1;
    start  = 1'b0;
    scores = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_idx", {30'd0, class_idx}, 32'd0);
    chk("rst_val", max_score, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].s, vecs[i].idx, vecs[i].val);

    // Back-to-back: second start presented in the DONE cycle.
    @(negedge clk);
    scores = V_MIXED;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_done_valid", {31'd0, valid_out}, 32'd0);
    scores = V_INF;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    scores = V_LATE;
    chk("b2b_first_valid", {31'd0, valid_out}, 32'd1);
    chk("b2b_first_idx", {30'd0, class_idx}, 32'd1);
    chk("b2b_no_overlap", {31'd0, busy}, 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk("b2b_busy", {31'd0, busy}, 32'd1);
    end while (!valid_out && n < 12);
    chk("b2b_spacing", n, 32'd4);
    chk("b2b_second_idx", {30'd0, class_idx}, 32'd2);
    chk("b2b_second_val", max_score, 32'h7F800000);

    // Start during SCAN must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    scores = V_TIE;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    scores = V_MIXED;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pulses  = 0;
    first_k = 0;
    for (int k = 3; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("ign_pulses", pulses, 32'd1);
    chk("ign_latency", first_k, 32'd4);
    chk("ign_idx", {30'd0, class_idx}, 32'd0);
    chk("ign_val", max_score, 32'h3F800000);

    // Reset asserted mid-scan.
    @(negedge clk);
    scores = V_MIXED;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_idx", {30'd0, class_idx}, 32'd0);
    chk("mid_rst_val", max_score, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    chk("mid_rst_no_valid", pulses, 32'd0);
    run_vec("after_rst", V_NAN, 2'd1, 32'hBF800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
